// File: rtl/store_queue_if.sv
// store_queue_if: groups the allocate, address, CDB, commit, load-query and
// memory-write signals of the store queue. The slave modport is the queue
// side and the master modport is the pipeline/memory side.
interface store_queue_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // store allocate handshake
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [ID_W-1:0]        alloc_id;
  logic [DATA_W-1:0]      alloc_data;
  logic [ID_W-1:0]        alloc_data_id;
  logic                   alloc_data_rdy;
  // computed store address
  logic                   addr_valid;
  logic [ID_W-1:0]        addr_id;
  logic [ADDR_W-1:0]      addr;
  // result broadcast {tag, value}
  logic                   cdb_valid;
  logic [ID_W+DATA_W-1:0] cdb;
  // retire and squash
  logic                   commit_valid;
  logic [ID_W-1:0]        commit_id;
  logic                   commit_kill;
  logic                   flush;
  // load disambiguation query
  logic                   ld_valid;
  logic [ADDR_W-1:0]      ld_addr;
  logic                   ld_hit;
  logic                   ld_stall;
  logic [DATA_W-1:0]      ld_data;
  // memory write port
  logic                   mem_valid;
  logic                   mem_ready;
  logic [ID_W-1:0]        mem_id;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  // occupancy
  logic [CNT_W-1:0]       count;

  modport slave (
    input  alloc_valid, alloc_id, alloc_data, alloc_data_id, alloc_data_rdy,
    output alloc_ready,
    input  addr_valid, addr_id, addr,
    input  cdb_valid, cdb,
    input  commit_valid, commit_id, commit_kill, flush,
    input  ld_valid, ld_addr,
    output ld_hit, ld_stall, ld_data,
    output mem_valid, mem_id, mem_addr, mem_data,
    input  mem_ready,
    output count
  );

  modport master (
    output alloc_valid, alloc_id, alloc_data, alloc_data_id, alloc_data_rdy,
    input  alloc_ready,
    output addr_valid, addr_id, addr,
    output cdb_valid, cdb,
    output commit_valid, commit_id, commit_kill, flush,
    output ld_valid, ld_addr,
    input  ld_hit, ld_stall, ld_data,
    input  mem_valid, mem_id, mem_addr, mem_data,
    output mem_ready,
    input  count
  );
endinterface

// File: rtl/store_queue.sv
// store_queue: circular store buffer with CDB data wakeup, address capture,
// commit/kill marking, flush recovery, in-order memory write-out and a
// combinational load disambiguation query.
// Optional feature: define STQ_FORWARD_EN to enable store-to-load forwarding;
// without it an address match only stalls the load.
// The interface instance must be built with the same DEPTH/ADDR_W/DATA_W/ID_W.
module store_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
) (
  input logic         clk,
  input logic         nrst,
  store_queue_if.slave sq
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   data_id;
    logic              data_rdy;
    logic [ADDR_W-1:0] addr;
    logic              addr_rdy;
    logic              committed;
    logic              killed;
  } entry_t;

  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             head_e_s;
  entry_t             new_e_s;
  logic               alloc_ready_s;
  logic               mem_valid_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W-1:0]   n_commit_s;
  logic [ID_W-1:0]    cdb_tag_s;
  logic [DATA_W-1:0]  cdb_val_s;

  logic               any_unaddr_s;
  logic               match_s;
  logic               match_rdy_s;
  logic [DATA_W-1:0]  match_data_s;
  logic               io_s;
  logic               stall_s;

  // Advance a pointer by one, wrapping at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer plus an offset of at most DEPTH, modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(p) + SUM_W'(n);
    if (sum >= SUM_W'(DEPTH)) begin
      sum = sum - SUM_W'(DEPTH);
    end
    return sum[PTR_W-1:0];
  endfunction

  assign cdb_tag_s = sq.cdb[ID_W+DATA_W-1:DATA_W];
  assign cdb_val_s = sq.cdb[DATA_W-1:0];
  assign head_e_s  = entry_q[head_q];

  // Handshake and memory-port outputs, all derived from current state and inputs.
  always_comb begin
    // full test uses the pre-pop count so a same-cycle pop never frees a slot
    alloc_ready_s = (count_q < CNT_W'(DEPTH)) && !sq.flush;
    mem_valid_s   = head_e_s.valid && head_e_s.committed && head_e_s.addr_rdy &&
                    head_e_s.data_rdy && !head_e_s.killed;
    push_s        = sq.alloc_valid && alloc_ready_s;
    // killed stores leave the head without ever touching memory
    pop_s         = (mem_valid_s && sq.mem_ready) ||
                    (head_e_s.valid && head_e_s.committed && head_e_s.killed);
    sq.alloc_ready = alloc_ready_s;
    sq.mem_valid   = mem_valid_s;
    sq.mem_id      = mem_valid_s ? head_e_s.id   : '0;
    sq.mem_addr    = mem_valid_s ? head_e_s.addr : '0;
    sq.mem_data    = mem_valid_s ? head_e_s.data : '0;
    sq.count       = count_q;
  end

  // Build the entry being allocated, including same-cycle CDB bypass.
  always_comb begin
    new_e_s         = '0;
    new_e_s.valid   = 1'b1;
    new_e_s.id      = sq.alloc_id;
    new_e_s.data_id = sq.alloc_data_id;
    if (sq.alloc_data_rdy) begin
      new_e_s.data     = sq.alloc_data;
      new_e_s.data_rdy = 1'b1;
    end else if (sq.cdb_valid && (cdb_tag_s == sq.alloc_data_id)) begin
      new_e_s.data     = cdb_val_s;
      new_e_s.data_rdy = 1'b1;
    end else begin
      new_e_s.data_rdy = 1'b0;
    end
  end

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    n_commit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid && entry_q[i].committed) begin
        n_commit_s = n_commit_s + CNT_W'(1);
      end
      if (sq.cdb_valid && entry_q[i].valid && !entry_q[i].data_rdy &&
          (entry_q[i].data_id == cdb_tag_s)) begin
        entry_d[i].data     = cdb_val_s;
        entry_d[i].data_rdy = 1'b1;
      end
      if (sq.addr_valid && entry_q[i].valid && (entry_q[i].id == sq.addr_id)) begin
        entry_d[i].addr     = sq.addr;
        entry_d[i].addr_rdy = 1'b1;
      end
      if (sq.commit_valid && entry_q[i].valid && (entry_q[i].id == sq.commit_id)) begin
        entry_d[i].committed = 1'b1;
        entry_d[i].killed    = sq.commit_kill;
      end
      // squash drops everything not yet retired
      if (sq.flush && entry_q[i].valid && !entry_q[i].committed) begin
        entry_d[i] = '0;
      end
    end
    if (pop_s) begin
      entry_d[head_q] = '0;
      head_d          = ptr_inc(head_q);
    end
    if (sq.flush) begin
      // committed entries are contiguous from head, so tail lands just past them
      tail_d  = ptr_add(head_q, n_commit_s);
      count_d = n_commit_s - CNT_W'(pop_s);
    end else begin
      if (push_s) begin
        entry_d[tail_q] = new_e_s;
        tail_d          = ptr_inc(tail_q);
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // State registers with synchronous active-high reset; reset abandons any pending write.
  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Scan resident stores oldest to youngest; the last address match is the youngest.
  always_comb begin
    any_unaddr_s = 1'b0;
    match_s      = 1'b0;
    match_rdy_s  = 1'b0;
    match_data_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_q[ptr_add(head_q, CNT_W'(k))].valid &&
          !entry_q[ptr_add(head_q, CNT_W'(k))].killed) begin
        if (!entry_q[ptr_add(head_q, CNT_W'(k))].addr_rdy) begin
          any_unaddr_s = 1'b1;
        end else if (entry_q[ptr_add(head_q, CNT_W'(k))].addr == sq.ld_addr) begin
          match_s      = 1'b1;
          match_rdy_s  = entry_q[ptr_add(head_q, CNT_W'(k))].data_rdy;
          match_data_s = entry_q[ptr_add(head_q, CNT_W'(k))].data;
        end else begin
          match_s = match_s;
        end
      end
    end
  end

  // Load query outputs: stall on unknown older addresses or I/O with stores pending.
  always_comb begin
    io_s        = &sq.ld_addr;
    stall_s     = any_unaddr_s || (io_s && (count_q != '0));
    sq.ld_hit   = 1'b0;
    sq.ld_stall = 1'b0;
    sq.ld_data  = '0;
`ifdef STQ_FORWARD_EN
    stall_s = stall_s || (match_s && !match_rdy_s);
    if (sq.ld_valid) begin
      sq.ld_stall = stall_s;
      if (match_s && match_rdy_s && !stall_s && !io_s) begin
        sq.ld_hit  = 1'b1;
        sq.ld_data = match_data_s;
      end else begin
        sq.ld_hit  = 1'b0;
      end
    end else begin
      sq.ld_stall = 1'b0;
    end
`else
    // without forwarding any older store to the same address blocks the load
    stall_s = stall_s || match_s;
    if (sq.ld_valid) begin
      sq.ld_stall = stall_s;
    end else begin
      sq.ld_stall = 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: scenario tasks for the store queue with a memory-write
// scoreboard; committed stores queue their expected writes and a negedge
// monitor pops and compares them as the queue drains.
module tb_store_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 6;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic nrst;
  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  sb[$];
  wr_t  mon_e;

  store_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) sq ();

  store_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .nrst(nrst),
    .sq  (sq)
  );

  always #5 clk = ~clk;

  // scoreboard consumer: every accepted memory write must match the oldest expectation
  always @(negedge clk) begin
    if (!nrst && sq.mem_valid && sq.mem_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mem_unexpected got id=%0d addr=%0h data=%0h, none expected",
                 sq.mem_id, sq.mem_addr, sq.mem_data);
      end else begin
        mon_e = sb.pop_front();
        if ({sq.mem_id, sq.mem_addr, sq.mem_data} !== {mon_e.id, mon_e.addr, mon_e.data}) begin
          n_fail++;
          $display("FAIL mem_write got id=%0d addr=%0h data=%0h exp id=%0d addr=%0h data=%0h",
                   sq.mem_id, sq.mem_addr, sq.mem_data, mon_e.id, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    sq.alloc_valid = 1'b0; sq.alloc_id = '0; sq.alloc_data = '0;
    sq.alloc_data_id = '0; sq.alloc_data_rdy = 1'b0;
    sq.addr_valid = 1'b0; sq.addr_id = '0; sq.addr = '0;
    sq.cdb_valid = 1'b0; sq.cdb = '0;
    sq.commit_valid = 1'b0; sq.commit_id = '0; sq.commit_kill = 1'b0; sq.flush = 1'b0;
    sq.ld_valid = 1'b0; sq.ld_addr = '0; sq.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    clr_inputs();
    cyc();
    cyc();
    nrst = 1'b0;
    sb.delete();
  endtask

  task automatic alloc_one(input logic [ID_W-1:0] id, input logic [ID_W-1:0] did,
                           input logic [DATA_W-1:0] data, input logic rdy);
    sq.alloc_valid = 1'b1; sq.alloc_id = id; sq.alloc_data_id = did;
    sq.alloc_data = data; sq.alloc_data_rdy = rdy;
    cyc();
    sq.alloc_valid = 1'b0;
  endtask

  task automatic addr_one(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a);
    sq.addr_valid = 1'b1; sq.addr_id = id; sq.addr = a;
    cyc();
    sq.addr_valid = 1'b0;
  endtask

  task automatic commit_one(input logic [ID_W-1:0] id, input logic kill);
    sq.commit_valid = 1'b1; sq.commit_id = id; sq.commit_kill = kill;
    cyc();
    sq.commit_valid = 1'b0; sq.commit_kill = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    clr_inputs();
    cyc();
    cyc();
    n_tests++; if (sq.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", sq.count); end
    n_tests++; if (sq.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got %b exp 1", sq.alloc_ready); end
    n_tests++; if ({sq.mem_valid, sq.mem_id, sq.mem_addr, sq.mem_data} !== '0) begin n_fail++; $display("FAIL reset_mem got v=%b a=%0h exp all 0", sq.mem_valid, sq.mem_addr); end
    n_tests++; if ({sq.ld_hit, sq.ld_stall, sq.ld_data} !== '0) begin n_fail++; $display("FAIL reset_ld got hit=%b stall=%b exp 0", sq.ld_hit, sq.ld_stall); end
    nrst = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sq.alloc_valid = 1'b1; sq.alloc_id = ID_W'(i); sq.alloc_data = DATA_W'(i);
      sq.alloc_data_rdy = 1'b1;
      #1;
      n_tests++;
      if (sq.alloc_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL full_alloc_ready[%0d] got %b exp %b", i, sq.alloc_ready, (i < 4));
      end
      cyc();
    end
    sq.alloc_valid = 1'b0;
    n_tests++; if (sq.count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", sq.count); end
    n_tests++; if (dut.tail_q !== 2'd0) begin n_fail++; $display("FAIL full_tail_wrap got %0d exp 0", dut.tail_q); end
  endtask

  task automatic test_bypass();
    do_reset();
    sq.alloc_valid = 1'b1; sq.alloc_id = 6'd3; sq.alloc_data_id = 6'd9;
    sq.alloc_data = '0; sq.alloc_data_rdy = 1'b0;
    sq.cdb_valid = 1'b1; sq.cdb = {6'd9, 32'h0000_00AB};
    cyc();
    sq.alloc_valid = 1'b0; sq.cdb_valid = 1'b0;
    n_tests++; if (dut.entry_q[0].data_rdy !== 1'b1 || dut.entry_q[0].data !== 32'hAB) begin n_fail++; $display("FAIL bypass_entry got rdy=%b data=%0h exp rdy=1 data=ab", dut.entry_q[0].data_rdy, dut.entry_q[0].data); end
    addr_one(6'd3, 32'h40);
    sb.push_back('{id: 6'd3, addr: 32'h40, data: 32'hAB});
    commit_one(6'd3, 1'b0);
    // late wakeup: store waits for its data on the CDB
    alloc_one(6'd4, 6'd12, 32'h0, 1'b0);
    addr_one(6'd4, 32'h44);
    commit_one(6'd4, 1'b0);
    n_tests++; if (sq.mem_valid !== 1'b1 || sq.mem_id !== 6'd3) begin n_fail++; $display("FAIL bypass_head_ready got v=%b id=%0d exp v=1 id=3", sq.mem_valid, sq.mem_id); end
    sb.push_back('{id: 6'd4, addr: 32'h44, data: 32'h55});
    sq.mem_ready = 1'b1;
    cyc();
    n_tests++; if (sq.mem_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_wait got mem_valid=%b exp 0", sq.mem_valid); end
    sq.cdb_valid = 1'b1; sq.cdb = {6'd12, 32'h0000_0055};
    cyc();
    sq.cdb_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    sq.mem_ready = 1'b0;
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL bypass_drain_timeout got %0d pending exp 0", sb.size()); end
    n_tests++; if (sq.count !== 3'd0) begin n_fail++; $display("FAIL bypass_count got %0d exp 0", sq.count); end
  endtask

  task automatic test_forward();
    logic            e_hit;
    logic            e_stall;
    logic [DATA_W-1:0] e_data;
`ifdef STQ_FORWARD_EN
    e_hit = 1'b1; e_stall = 1'b0; e_data = 32'h22;
`else
    e_hit = 1'b0; e_stall = 1'b1; e_data = 32'h0;
`endif
    do_reset();
    alloc_one(6'd1, 6'd0, 32'h11, 1'b1);
    alloc_one(6'd2, 6'd0, 32'h22, 1'b1);
    addr_one(6'd1, 32'h100);
    addr_one(6'd2, 32'h100);
    sq.ld_valid = 1'b1; sq.ld_addr = 32'h100;
    #1;
    n_tests++; if ({sq.ld_hit, sq.ld_stall, sq.ld_data} !== {e_hit, e_stall, e_data}) begin n_fail++; $display("FAIL fwd_youngest got hit=%b stall=%b data=%0h exp hit=%b stall=%b data=%0h", sq.ld_hit, sq.ld_stall, sq.ld_data, e_hit, e_stall, e_data); end
    sq.ld_addr = 32'h104;
    #1;
    n_tests++; if ({sq.ld_hit, sq.ld_stall} !== 2'b00) begin n_fail++; $display("FAIL fwd_nomatch got hit=%b stall=%b exp 0 0", sq.ld_hit, sq.ld_stall); end
    sq.ld_addr = '1;
    #1;
    n_tests++; if ({sq.ld_hit, sq.ld_stall} !== 2'b01) begin n_fail++; $display("FAIL fwd_io got hit=%b stall=%b exp 0 1", sq.ld_hit, sq.ld_stall); end
    sq.ld_valid = 1'b0; sq.ld_addr = 32'h100;
    #1;
    n_tests++; if ({sq.ld_hit, sq.ld_stall, sq.ld_data} !== '0) begin n_fail++; $display("FAIL fwd_idle got hit=%b stall=%b data=%0h exp 0", sq.ld_hit, sq.ld_stall, sq.ld_data); end
    sb.push_back('{id: 6'd1, addr: 32'h100, data: 32'h11});
    commit_one(6'd1, 1'b0);
    sb.push_back('{id: 6'd2, addr: 32'h100, data: 32'h22});
    commit_one(6'd2, 1'b0);
    sq.mem_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    sq.mem_ready = 1'b0;
    n_tests++; if (sb.size() != 0 || sq.count !== 3'd0) begin n_fail++; $display("FAIL fwd_drain got pending=%0d count=%0d exp 0 0", sb.size(), sq.count); end
    sq.ld_valid = 1'b1; sq.ld_addr = '1;
    #1;
    n_tests++; if (sq.ld_stall !== 1'b0) begin n_fail++; $display("FAIL io_empty got stall=%b exp 0", sq.ld_stall); end
    sq.ld_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    alloc_one(6'd7, 6'd0, 32'h77, 1'b1);
    sq.ld_valid = 1'b1; sq.ld_addr = 32'h200;
    #1;
    n_tests++; if ({sq.ld_hit, sq.ld_stall} !== 2'b01) begin n_fail++; $display("FAIL stall_unaddr got hit=%b stall=%b exp 0 1", sq.ld_hit, sq.ld_stall); end
    addr_one(6'd9, 32'h200);
    n_tests++; if (sq.ld_stall !== 1'b1) begin n_fail++; $display("FAIL stall_addr_nomatch_id got stall=%b exp 1", sq.ld_stall); end
    addr_one(6'd7, 32'h300);
    n_tests++; if ({sq.ld_hit, sq.ld_stall} !== 2'b00) begin n_fail++; $display("FAIL stall_resolved got hit=%b stall=%b exp 0 0", sq.ld_hit, sq.ld_stall); end
    sq.ld_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    alloc_one(6'd1, 6'd0, 32'h10, 1'b1);
    alloc_one(6'd2, 6'd0, 32'h20, 1'b1);
    alloc_one(6'd3, 6'd0, 32'h30, 1'b1);
    addr_one(6'd1, 32'h500);
    sb.push_back('{id: 6'd1, addr: 32'h500, data: 32'h10});
    commit_one(6'd1, 1'b0);
    sq.flush = 1'b1; sq.alloc_valid = 1'b1; sq.alloc_id = 6'd4; sq.alloc_data_rdy = 1'b1;
    #1;
    n_tests++; if (sq.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL flush_alloc_ready got %b exp 0", sq.alloc_ready); end
    cyc();
    sq.flush = 1'b0; sq.alloc_valid = 1'b0;
    n_tests++; if (sq.count !== 3'd1) begin n_fail++; $display("FAIL flush_count got %0d exp 1", sq.count); end
    n_tests++; if (dut.head_q !== 2'd0 || dut.tail_q !== 2'd1) begin n_fail++; $display("FAIL flush_tail got head=%0d tail=%0d exp 0 1", dut.head_q, dut.tail_q); end
    sq.mem_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    sq.mem_ready = 1'b0;
    n_tests++; if (sb.size() != 0 || sq.count !== 3'd0) begin n_fail++; $display("FAIL flush_drain got pending=%0d count=%0d exp 0 0", sb.size(), sq.count); end
    // flush in the same cycle the committed head is written out
    alloc_one(6'd5, 6'd0, 32'h50, 1'b1);
    alloc_one(6'd6, 6'd0, 32'h60, 1'b1);
    addr_one(6'd5, 32'h510);
    sb.push_back('{id: 6'd5, addr: 32'h510, data: 32'h50});
    commit_one(6'd5, 1'b0);
    sq.flush = 1'b1; sq.mem_ready = 1'b1;
    cyc();
    sq.flush = 1'b0; sq.mem_ready = 1'b0;
    n_tests++; if (sq.count !== 3'd0 || dut.head_q !== 2'd2 || dut.tail_q !== 2'd2) begin n_fail++; $display("FAIL flush_pop got count=%0d head=%0d tail=%0d exp 0 2 2", sq.count, dut.head_q, dut.tail_q); end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL flush_pop_write got pending=%0d exp 0", sb.size()); end
  endtask

  task automatic test_kill();
    do_reset();
    alloc_one(6'd6, 6'd0, 32'h66, 1'b1);
    addr_one(6'd6, 32'h80);
    sq.mem_ready = 1'b1;
    sq.commit_valid = 1'b1; sq.commit_id = 6'd6; sq.commit_kill = 1'b1;
    #1;
    n_tests++; if (sq.mem_valid !== 1'b0) begin n_fail++; $display("FAIL kill_precommit got mem_valid=%b exp 0", sq.mem_valid); end
    cyc();
    sq.commit_valid = 1'b0; sq.commit_kill = 1'b0;
    n_tests++; if (sq.mem_valid !== 1'b0 || sq.mem_addr !== 32'h0 || sq.count !== 3'd1) begin n_fail++; $display("FAIL kill_head got v=%b addr=%0h count=%0d exp 0 0 1", sq.mem_valid, sq.mem_addr, sq.count); end
    cyc();
    n_tests++; if (sq.mem_valid !== 1'b0 || sq.count !== 3'd0) begin n_fail++; $display("FAIL kill_pop got v=%b count=%0d exp 0 0", sq.mem_valid, sq.count); end
    sq.mem_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    alloc_one(6'd8, 6'd0, 32'h88, 1'b1);
    addr_one(6'd8, 32'h90);
    commit_one(6'd8, 1'b0);
    n_tests++; if (sq.mem_valid !== 1'b1 || sq.mem_data !== 32'h88) begin n_fail++; $display("FAIL midop_pending got v=%b data=%0h exp 1 88", sq.mem_valid, sq.mem_data); end
    nrst = 1'b1;
    cyc();
    nrst = 1'b0;
    n_tests++; if (sq.mem_valid !== 1'b0 || sq.mem_data !== 32'h0 || sq.count !== 3'd0) begin n_fail++; $display("FAIL midop_abort got v=%b data=%0h count=%0d exp 0 0 0", sq.mem_valid, sq.mem_data, sq.count); end
    sq.mem_ready = 1'b1;
    cyc();
    n_tests++; if (sq.mem_valid !== 1'b0 || sq.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL midop_after got v=%b ready=%b exp 0 1", sq.mem_valid, sq.alloc_ready); end
    sq.mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full();
    test_bypass();
    test_forward();
    test_stall();
    test_flush();
    test_kill();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of store entries (>=2, any integer).
REQ-002 SHALL have parameter ADDR_W, default 32, store/load address width.
REQ-003 SHALL have parameter DATA_W, default 32, store data width.
REQ-004 SHALL have parameter ID_W, default 6, ROB tag width.
REQ-005 SHALL have ports: clk  in  1  clock; nrst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: alloc_valid in 1, alloc_ready out 1, alloc_id in ID_W, alloc_data in DATA_W, alloc_data_id in ID_W, alloc_data_rdy in 1. Together these form the store allocate handshake.
REQ-007 SHALL have ports: addr_valid in 1, addr_id in ID_W, addr in ADDR_W. Together these deliver a computed store address.
REQ-008 SHALL have port: cdb_valid in 1, cdb in ID_W+DATA_W, carrying {tag, value} broadcast.
REQ-009 SHALL have ports: commit_valid in 1, commit_id in ID_W, commit_kill in 1, flush in 1. Together these carry retire and squash.
REQ-010 SHALL have ports: ld_valid in 1, ld_addr in ADDR_W, ld_hit out 1, ld_stall out 1, ld_data out DATA_W. Together these form the load disambiguation query.
REQ-011 SHALL have ports: mem_valid out 1, mem_ready in 1, mem_id out ID_W, mem_addr out ADDR_W, mem_data out DATA_W. Together these form the memory write port.
REQ-012 SHALL have port: count out $clog2(DEPTH+1), giving the number of occupied entries.

Function
REQ-013 SHALL keep entries in a circular buffer; head/tail SHALL wrap from DEPTH-1 to 0; each entry holds valid, id, data, data_id, data_rdy, addr, addr_rdy, committed, killed.
REQ-014 SHALL drive alloc_ready=1 iff count<DEPTH and flush=0; the full test uses pre-pop count, so a pop in the same cycle does not free space for a push.
REQ-015 SHALL, on alloc_valid&alloc_ready, write the entry at tail with valid=1, addr_rdy=0, committed=0, killed=0, and advance tail.
REQ-016 SHALL, when cdb_valid and cdb tag==alloc_data_id in the allocate cycle with alloc_data_rdy=0, store the CDB value with data_rdy=1 (bypass).
REQ-017 SHALL, on cdb_valid, load cdb data into every valid entry with data_rdy=0 and data_id==tag, setting data_rdy=1 next cycle.
REQ-018 SHALL, on addr_valid, write addr and set addr_rdy=1 in the valid entry with id==addr_id; a non-matching addr_valid is ignored.
REQ-019 SHALL, on commit_valid, set committed=1 and killed=commit_kill in the valid entry with id==commit_id.
REQ-020 SHALL drive mem_valid combinationally when the head entry is valid, committed, addr_rdy, data_rdy, and not killed; mem_* SHALL come from the head entry; mem_* SHALL be 0 when mem_valid=0.
REQ-021 SHALL pop the head on mem_valid&mem_ready, or in one cycle without mem_valid when the head is committed&killed; a popped entry SHALL be zeroed.
REQ-022 SHALL, on flush, clear all uncommitted entries and set tail to head+(number of committed entries) mod DEPTH; committed entries survive; a head pop in the same cycle is still honoured.
REQ-023 SHALL treat all resident entries as older than the load query; ld_* SHALL be combinational and 0 when ld_valid=0.
REQ-024 SHALL drive ld_stall=1 if any valid, non-killed entry has addr_rdy=0.
REQ-025 SHALL drive ld_stall=1 if the youngest addr-matching entry (nearest tail) has data_rdy=0.
REQ-026 SHALL drive ld_hit=1 and ld_data=data of the youngest addr-matching entry when it has data_rdy=1 and no stall condition exists.
REQ-027 SHALL, when ld_addr is all-ones (I/O space), never forward, and SHALL drive ld_stall=1 whenever count!=0.
REQ-028 SHALL, when there is no match and no stall condition, drive ld_hit=0 and ld_stall=0, meaning the load proceeds to memory.

Reset
REQ-029 SHALL, with nrst=1 at a clk edge, clear all entries, head, tail and count to 0; all outputs SHALL be 0 except alloc_ready=1.
REQ-030 SHALL abort any in-flight mem handshake on reset mid-operation, without completing it.

Configuration
REQ-031 SHALL, with STQ_FORWARD_EN defined, behave as REQ-024 to REQ-028.
REQ-032 SHALL, without STQ_FORWARD_EN, tie ld_hit and ld_data to 0 and drive ld_stall=1 on any addr match; REQ-024 and REQ-027 still apply.

Verification
REQ-033 SHALL verify, with DEPTH=4, 5 allocs back-to-back: alloc_ready=0 on the 5th, count=4, and tail wraps to 0.
REQ-034 SHALL verify alloc id3 with data_id 9 alongside cdb {9,0xAB}: the entry has data_rdy=1 and data 0xAB.
REQ-035 SHALL verify stores to 0x100 (0x11, then 0x22), both addr_rdy, then load 0x100: ld_hit=1 and ld_data=0x22.
REQ-036 SHALL verify one store with addr_rdy=0 and a load to 0x200: ld_stall=1, and after addr_valid to 0x300, ld_hit=0 and ld_stall=0.
REQ-037 SHALL verify 3 entries with the head committed, then flush: count=1, tail=head+1, and alloc_ready=0 during the flush cycle.
REQ-038 SHALL verify a head committed with commit_kill=1: it pops in 1 cycle with mem_valid never asserted.
